string_uart_tx: RTL and testbench

- Downstream consumer of board_to_string; drains its character stream onto a UART serial line (8N1, LSB first).
- Paces the producer by pulsing print_nxt once per character it has latched.
- Detects end of string when the producer raises done, then returns to idle and reports completion to the top-level game FSM.

---
 rtl/string_uart_tx.sv | 138 +++++++++++++
 tb/tb_string_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/string_uart_tx.sv
// string_uart_tx: drains a producer's character stream onto an 8N1 UART line.
// Ports: clk, rst (async high), start, char_in[7:0], src_done -> print_nxt, tx, busy, frame_done, char_count[10:0].
module string_uart_tx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  char_in,
  input  logic        src_done,
  output logic        print_nxt,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [10:0] char_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    SET_MAX = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  baud_q;
  logic [CW-1:0]  baud_d;
  logic [3:0]     settle_q;
  logic [2:0]     bit_q;
  logic [2:0]     bit_d;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           pn_q;
  logic           busy_q;
  logic           fd_q;
  logic [10:0]    cnt_q;
  logic           bit_end;

  // Baud counter reloads to 0 on every bit boundary.
  always_comb begin
    bit_end = (baud_q == CNT_MAX);
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      settle_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      pn_q     <= 1'b0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pn_q <= 1'b0;
      fd_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (start) begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        // Give the producer time to present its next character.
        S_SETTLE: begin
          if (settle_q == SET_MAX) begin
            state_q <= S_LOAD;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_LOAD: begin
          if (src_done) begin
            state_q <= S_IDLE;
            fd_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            shift_q <= char_in;
            pn_q    <= 1'b1;
            cnt_q   <= cnt_q + 11'd1;
            state_q <= S_START;
            tx_q    <= 1'b0;
            baud_q  <= '0;
          end
        end
        S_START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        S_DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_d;
              tx_q  <= shift_q[bit_d];
            end
          end
        end
        S_STOP: begin
          baud_q <= baud_d;
          if (bit_end) begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign print_nxt  = pn_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_string_uart_tx.sv
// tb_string_uart_tx: randomized scoreboard bench for string_uart_tx.
// A UART decoder monitor pops expected bytes; an event monitor times the pulses.
module tb_string_uart_tx;

  localparam int C = 4;
  localparam int S = 2;
  localparam int T = 10 * C + S + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  char_in;
  logic        src_done;
  logic        print_nxt;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [10:0] char_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pn_count = 0;
  int fd_count = 0;
  int pn_times[$];
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;

  string_uart_tx #(
    .CLKS_PER_BIT(C),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .char_in(char_in),
    .src_done(src_done),
    .print_nxt(print_nxt),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done),
    .char_count(char_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Producer model: presents the head of src_q, advances on print_nxt.
  initial begin
    char_in = 8'h00;
    src_done = 1'b1;
    forever begin
      @(negedge clk);
      if (print_nxt && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        char_in = src_q[0];
        src_done = 1'b0;
      end else begin
        char_in = 8'($urandom);
        src_done = 1'b1;
      end
    end
  end

  // UART decoder: samples every clock so bit widths are checked too.
  initial begin
    logic prev;
    logic smp[0:10*C-1];
    logic [7:0] b;
    logic lvl;
    int bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx) begin
        for (int j = 0; j < 10 * C; j++) begin
          if (j > 0) @(negedge clk);
          smp[j] = tx;
        end
        for (int i = 0; i < 8; i++) b[i] = smp[(i + 1) * C + C / 2];
        bad = 0;
        for (int j = 0; j < 10 * C; j++) begin
          if (j / C == 0) lvl = 1'b0;
          else if (j / C == 9) lvl = 1'b1;
          else lvl = smp[(j / C) * C + C / 2];
          if (smp[j] !== lvl) bad++;
        end
        if (mon_en) begin
          chk("frame_shape", bad, 0);
          chk("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("byte", b, exp_q.pop_front());
        end
      end
      prev = tx;
    end
  end

  // Pulse monitor.
  initial begin
    bit pn_prev;
    pn_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (print_nxt || frame_done)
          chk("pn_fd_excl", print_nxt && frame_done, 0);
        if (print_nxt) begin
          chk("pn_consec", pn_prev, 0);
          pn_count++;
          pn_times.push_back(cyc);
        end
        if (frame_done) fd_count++;
      end
      pn_prev = print_nxt;
    end
  end

  task automatic run_string(input logic [7:0] s[$], input bit repulse);
    int n, pn0, fd0, es, efd, bound;
    bit got;
    n = s.size();
    foreach (s[i]) begin
      src_q.push_back(s[i]);
      exp_q.push_back(s[i]);
    end
    pn_times.delete();
    pn0 = pn_count;
    fd0 = fd_count;
    start = 1'b1;
    @(posedge clk);
    #1 es = cyc;
    chk("busy_on_start", busy, 1);
    chk("count_clear", char_count, 0);
    @(negedge clk);
    start = 1'b0;
    bound = (n + 1) * T + 20;
    got = 1'b0;
    efd = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done) begin
        got = 1'b1;
        efd = cyc;
        break;
      end
      if (repulse && $urandom_range(0, 5) == 0) start = 1'b1;
    end
    chk("frame_done_seen", got, 1);
    if (got) begin
      chk("fd_latency", efd - es, S + 1 + n * T);
      chk("char_count", char_count, n);
      chk("busy_off", busy, 0);
    end
    #1;
    chk("pn_count", pn_count - pn0, n);
    chk("fd_count", fd_count - fd0, 1);
    chk("bytes_drained", exp_q.size(), 0);
    if (pn_times.size() > 0) chk("first_pn", pn_times[0] - es, S + 1);
    for (int i = 1; i < pn_times.size(); i++)
      chk("pn_spacing", pn_times[i] - pn_times[i-1], T);
    if (!got) begin
      src_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int es, n, bad;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pn", print_nxt, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_count", char_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while data bit 3 is on the line.
    src_q.push_back(8'hA5);
    start = 1'b1;
    @(posedge clk);
    #1 es = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < es + S + 2 + 4 * C) @(posedge clk);
    #2;
    chk("busy_pre_rst", busy, 1);
    chk("tx_bit3", tx, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pn", print_nxt, 0);
    chk("mid_rst_count", char_count, 0);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || print_nxt !== 1'b0) bad++;
    end
    chk("quiet_after_rst", bad, 0);
    mon_en = 1'b1;

    q = {8'h41};
    run_string(q, 1'b0);
    q = {8'h32, 8'h30, 8'h34, 8'h38, 8'h0A};
    run_string(q, 1'b0);
    q = {};
    run_string(q, 1'b0);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_string(q, 1'b1);
    end
    q = {8'h00, 8'hFF};
    run_string(q, 1'b0);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
